regfile_port_arbiter: RTL and testbench

Shares the CPU register file's single access slot between the core pipeline and the debug module. Each cycle it grants at most one request, either a read or a write. It drives the register file enables and addresses, and returns registered read data one cycle later to the requester that issued the read. It sits between the decode/writeback stages, the debug module and `register_file`.

---
 rtl/regfile_arb_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 34 +++
 rtl/regfile_port_arbiter.sv | 131 +++++++++++++
 tb/tb_regfile_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared encodings for the register-file port arbiter: response owner and requester ids.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CORE = 2'd1,
    OWNER_DBG  = 2'd2
  } owner_e;

  localparam int unsigned REQ_CORE = 0;
  localparam int unsigned REQ_DBG  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; one-hot grant, last_grant flop remembers the previous winner.
module rr_arbiter2
  import regfile_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_grant_q;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    gnt = 2'b00;
    if (rst) begin
      if (req[REQ_CORE] && req[REQ_DBG]) begin
        gnt[REQ_CORE] = last_grant_q;
        gnt[REQ_DBG]  = ~last_grant_q;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= 1'(REQ_DBG);
    end else if (|gnt) begin
      last_grant_q <= gnt[REQ_DBG];
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file's single access slot between the core pipeline and the debug module.
// Debug port arbitration is built only when REGFILE_ARB_DEBUG_EN is defined.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int unsigned reg_width  = 5,
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req_valid,
  output logic                  core_req_ready,
  input  logic                  core_req_write,
  input  logic [reg_width-1:0]  core_req_rs1,
  input  logic [reg_width-1:0]  core_req_rs2,
  input  logic                  core_req_rs2_en,
  input  logic [reg_width-1:0]  core_req_rd,
  input  logic [data_width-1:0] core_req_wdata,
  output logic                  core_resp_valid,
  output logic [data_width-1:0] core_resp_rs1_data,
  output logic [data_width-1:0] core_resp_rs2_data,
  input  logic                  dbg_req_valid,
  output logic                  dbg_req_ready,
  input  logic                  dbg_req_write,
  input  logic [reg_width-1:0]  dbg_req_addr,
  input  logic [data_width-1:0] dbg_req_wdata,
  output logic                  dbg_resp_valid,
  output logic [data_width-1:0] dbg_resp_data,
  output logic                  rf_rd_en,
  output logic                  rf_rs1_en,
  output logic                  rf_rs2_en,
  output logic [reg_width-1:0]  rf_rd,
  output logic [reg_width-1:0]  rf_rs1,
  output logic [reg_width-1:0]  rf_rs2,
  output logic [data_width-1:0] rf_rd_din,
  input  logic [data_width-1:0] rf_rs1_dout,
  input  logic [data_width-1:0] rf_rs2_dout
);

  logic   core_gnt_c;
  logic   dbg_gnt_c;
  owner_e owner_q;
  owner_e owner_d_c;
  logic   rs2_en_q;

`ifdef REGFILE_ARB_DEBUG_EN
  logic [1:0] arb_req_c;
  logic [1:0] arb_gnt_c;

  assign arb_req_c[REQ_CORE] = core_req_valid;
  assign arb_req_c[REQ_DBG]  = dbg_req_valid;

  rr_arbiter2 u_rr_arbiter2 (
    .clk (clk),
    .rst (rst),
    .req (arb_req_c),
    .gnt (arb_gnt_c)
  );

  assign core_gnt_c = arb_gnt_c[REQ_CORE];
  assign dbg_gnt_c  = arb_gnt_c[REQ_DBG];
`else
  logic unused_dbg_valid;

  assign unused_dbg_valid = dbg_req_valid;
  assign core_gnt_c       = rst & core_req_valid;
  assign dbg_gnt_c        = 1'b0;
`endif

  assign core_req_ready = core_gnt_c;
  assign dbg_req_ready  = dbg_gnt_c;

  // Steer the granted request onto the file ports; writes never enable a read port.
  always_comb begin
    rf_rd_en  = 1'b0;
    rf_rs1_en = 1'b0;
    rf_rs2_en = 1'b0;
    rf_rd     = '0;
    rf_rs1    = '0;
    rf_rs2    = '0;
    rf_rd_din = '0;
    owner_d_c = OWNER_NONE;
    if (core_gnt_c) begin
      if (core_req_write) begin
        rf_rd_en  = 1'b1;
        rf_rd     = core_req_rd;
        rf_rd_din = core_req_wdata;
      end else begin
        rf_rs1_en = 1'b1;
        rf_rs1    = core_req_rs1;
        rf_rs2_en = core_req_rs2_en;
        rf_rs2    = core_req_rs2;
        owner_d_c = OWNER_CORE;
      end
    end else if (dbg_gnt_c) begin
      if (dbg_req_write) begin
        rf_rd_en  = 1'b1;
        rf_rd     = dbg_req_addr;
        rf_rd_din = dbg_req_wdata;
      end else begin
        rf_rs1_en = 1'b1;
        rf_rs1    = dbg_req_addr;
        owner_d_c = OWNER_DBG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q  <= OWNER_NONE;
      rs2_en_q <= 1'b0;
    end else begin
      owner_q  <= owner_d_c;
      rs2_en_q <= core_gnt_c & ~core_req_write & core_req_rs2_en;
    end
  end

  // Responses come straight from the file's registered outputs; reset drops any pending one.
  assign core_resp_valid    = rst & (owner_q == OWNER_CORE);
  assign core_resp_rs1_data = core_resp_valid ? rf_rs1_dout : '0;
  assign core_resp_rs2_data = (core_resp_valid && rs2_en_q) ? rf_rs2_dout : '0;

`ifdef REGFILE_ARB_DEBUG_EN
  assign dbg_resp_valid = rst & (owner_q == OWNER_DBG);
  assign dbg_resp_data  = dbg_resp_valid ? rf_rs1_dout : '0;
`else
  assign dbg_resp_valid = 1'b0;
  assign dbg_resp_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: register-file stand-in plus a golden register/turn model.
module tb_regfile_port_arbiter;

  logic        clk;
  logic        rst;
  logic        core_req_valid, core_req_ready, core_req_write, core_req_rs2_en;
  logic [4:0]  core_req_rs1, core_req_rs2, core_req_rd;
  logic [31:0] core_req_wdata;
  logic        core_resp_valid;
  logic [31:0] core_resp_rs1_data, core_resp_rs2_data;
  logic        dbg_req_valid, dbg_req_ready, dbg_req_write;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_resp_valid;
  logic [31:0] dbg_resp_data;
  logic        rf_rd_en, rf_rs1_en, rf_rs2_en;
  logic [4:0]  rf_rd, rf_rs1, rf_rs2;
  logic [31:0] rf_rd_din, rf_rs1_dout, rf_rs2_dout;

  int checks;
  int failures;

  regfile_port_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_write(core_req_write), .core_req_rs1(core_req_rs1),
    .core_req_rs2(core_req_rs2), .core_req_rs2_en(core_req_rs2_en),
    .core_req_rd(core_req_rd), .core_req_wdata(core_req_wdata),
    .core_resp_valid(core_resp_valid), .core_resp_rs1_data(core_resp_rs1_data),
    .core_resp_rs2_data(core_resp_rs2_data),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata), .dbg_resp_valid(dbg_resp_valid),
    .dbg_resp_data(dbg_resp_data),
    .rf_rd_en(rf_rd_en), .rf_rs1_en(rf_rs1_en), .rf_rs2_en(rf_rs2_en),
    .rf_rd(rf_rd), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd_din(rf_rd_din),
    .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file stand-in: x0 hard-wired to zero, read data registered.
  logic [31:0] mem [32];
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      rf_rs1_dout <= '0;
      rf_rs2_dout <= '0;
    end else begin
      if (rf_rd_en && rf_rd != 5'd0) mem[rf_rd] <= rf_rd_din;
      if (rf_rs1_en) rf_rs1_dout <= mem[rf_rs1];
      if (rf_rs2_en) rf_rs2_dout <= mem[rf_rs2];
    end
  end

  // Golden model state: architectural register values, whose turn it is, pending responses.
  logic [31:0] ref_regs [32];
  bit          last_dbg;
  bit          p_core, p_dbg, p_rs2en;
  logic [31:0] p_rs1, p_rs2, p_dbg_data;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ref_regs[i] = '0;
    last_dbg = 1'b1;
    p_core   = 1'b0;
    p_dbg    = 1'b0;
    p_rs2en  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_core(input bit v, input bit w, input logic [4:0] rs1, input logic [4:0] rs2,
                            input bit rs2en, input logic [4:0] rd, input logic [31:0] wd);
    core_req_valid  = v;
    core_req_write  = w;
    core_req_rs1    = rs1;
    core_req_rs2    = rs2;
    core_req_rs2_en = rs2en;
    core_req_rd     = rd;
    core_req_wdata  = wd;
  endtask

  task automatic drive_dbg(input bit v, input bit w, input logic [4:0] a, input logic [31:0] wd);
    dbg_req_valid = v;
    dbg_req_write = w;
    dbg_req_addr  = a;
    dbg_req_wdata = wd;
  endtask

  task automatic idle();
    drive_core(0, 0, 5'd0, 5'd0, 0, 5'd0, 32'd0);
    drive_dbg(0, 0, 5'd0, 32'd0);
  endtask

  // One clock: check grant/ports/responses mid-cycle, then advance the model across the edge.
  task automatic cycle();
    bit         wc, wd, ecv, edv;
    logic [2:0] een;
    @(negedge clk);
    wc = 1'b0;
    wd = 1'b0;
    if (rst) begin
`ifdef REGFILE_ARB_DEBUG_EN
      if (core_req_valid && dbg_req_valid) begin
        wc = last_dbg;
        wd = !last_dbg;
      end else begin
        wc = core_req_valid;
        wd = dbg_req_valid;
      end
`else
      wc = core_req_valid;
`endif
    end
    chk("core_ready", 64'(core_req_ready), 64'(wc));
    chk("dbg_ready", 64'(dbg_req_ready), 64'(wd));
    if (wc) een = core_req_write ? 3'b100 : {2'b01, core_req_rs2_en};
    else if (wd) een = dbg_req_write ? 3'b100 : 3'b010;
    else een = 3'b000;
    chk("rf_en", 64'({rf_rd_en, rf_rs1_en, rf_rs2_en}), 64'(een));
    if (een[2]) begin
      chk("rf_rd", 64'(rf_rd), 64'(wc ? core_req_rd : dbg_req_addr));
      chk("rf_rd_din", 64'(rf_rd_din), 64'(wc ? core_req_wdata : dbg_req_wdata));
    end
    if (een[1]) chk("rf_rs1", 64'(rf_rs1), 64'(wc ? core_req_rs1 : dbg_req_addr));
    if (een[0]) chk("rf_rs2", 64'(rf_rs2), 64'(core_req_rs2));
    if (!rst) chk("rf_addr_in_reset", 64'({rf_rd, rf_rs1, rf_rs2, rf_rd_din}), 64'd0);
    ecv = rst && p_core;
    edv = rst && p_dbg;
    chk("core_resp_valid", 64'(core_resp_valid), 64'(ecv));
    chk("dbg_resp_valid", 64'(dbg_resp_valid), 64'(edv));
    if (ecv) begin
      chk("core_rs1_data", 64'(core_resp_rs1_data), 64'(p_rs1));
      chk("core_rs2_data", 64'(core_resp_rs2_data), 64'(p_rs2en ? p_rs2 : 32'd0));
    end
    if (edv) chk("dbg_data", 64'(dbg_resp_data), 64'(p_dbg_data));
    if (!rst) begin
      model_reset();
    end else begin
      p_core     = wc && !core_req_write;
      p_rs2en    = core_req_rs2_en;
      p_rs1      = ref_regs[core_req_rs1];
      p_rs2      = ref_regs[core_req_rs2];
      p_dbg      = wd && !dbg_req_write;
      p_dbg_data = ref_regs[dbg_req_addr];
      if (wc && core_req_write && core_req_rd != 5'd0) ref_regs[core_req_rd] = core_req_wdata;
      if (wd && dbg_req_write && dbg_req_addr != 5'd0) ref_regs[dbg_req_addr] = dbg_req_wdata;
      if (wc) last_dbg = 1'b0;
      else if (wd) last_dbg = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    rst = 1'b0;
    idle();
    // Reset with requests pending: nothing may be granted or enabled.
    drive_core(1, 1, 5'd1, 5'd2, 1, 5'd3, 32'hA5A5_A5A5);
    drive_dbg(1, 0, 5'd4, 32'd0);
    cycle();
    cycle();
    rst = 1'b1;
    // Core write x5 then read rs1=5, rs2=0.
    drive_core(1, 1, 5'd0, 5'd0, 0, 5'd5, 32'hDEAD_BEEF);
    cycle();
    drive_core(1, 0, 5'd5, 5'd0, 1, 5'd0, 32'd0);
    cycle();
    idle();
    cycle();
    // Contention: core reads x5, debug reads x3, four cycles.
    drive_core(1, 0, 5'd5, 5'd5, 1, 5'd0, 32'd0);
    drive_dbg(1, 0, 5'd3, 32'd0);
    repeat (4) cycle();
    idle();
    cycle();
    // x0 write is forwarded but dropped by the file.
    drive_core(1, 1, 5'd0, 5'd0, 0, 5'd0, 32'h0000_1234);
    cycle();
    idle();
    drive_dbg(1, 0, 5'd0, 32'd0);
    cycle();
    drive_dbg(0, 0, 5'd0, 32'd0);
    drive_core(1, 0, 5'd0, 5'd0, 0, 5'd0, 32'd0);
    cycle();
    idle();
    cycle();
    // Same register: debug write x7 and core read x7 after a core grant.
    drive_core(1, 0, 5'd7, 5'd7, 1, 5'd0, 32'd0);
    cycle();
    drive_dbg(1, 1, 5'd7, 32'h0000_0055);
    cycle();
    drive_dbg(0, 0, 5'd0, 32'd0);
    cycle();
    idle();
    cycle();
    // Reset in the cycle after a core read grant.
    drive_core(1, 0, 5'd5, 5'd7, 1, 5'd0, 32'd0);
    cycle();
    idle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    drive_core(1, 0, 5'd5, 5'd7, 1, 5'd0, 32'd0);
    drive_dbg(1, 0, 5'd5, 32'd0);
    cycle();
    cycle();
    idle();
    cycle();
    // Randomized traffic on a small address set to force collisions.
    for (int n = 0; n < 400; n++) begin
      drive_core(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
                 5'($urandom_range(0, 7)), $urandom);
      drive_dbg(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 7)), $urandom);
      rst = ($urandom_range(0, 63) != 0);
      cycle();
    end
    rst = 1'b1;
    idle();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
